// File: rtl/dec_pkg.sv
// Shared mode and scan-state encodings for the dec_scan decoder.
package dec_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

  // Enable rising edge as seen against the previous-cycle enable.
  function automatic logic en_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/dec_tick_gen.sv
// Free-running prescaler: tick marks the last cycle of every PRESCALE-cycle window.
module dec_tick_gen
  import dec_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("dec_tick_gen: PRESCALE must be >= 1");
    end
  endgenerate

  logic [CW-1:0] cnt_r;

  // Window counter, restarted whenever the owner is not actively scanning.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_r <= '0;
    end else if (clear || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign tick = !clear && (cnt_r == LAST);

endmodule

// File: rtl/dec_scan.sv
// One-hot decoder with direct, single-pulse and auto-scan modes; all outputs registered.
module dec_scan
  import dec_pkg::*;
#(
  parameter  int N_SEL    = 2,
  parameter  int PRESCALE = 4,
  localparam int W        = 2 ** N_SEL
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [N_SEL-1:0] i_in,
  output logic [W-1:0]     o_out,
  output logic [N_SEL-1:0] o_idx,
  output logic             o_wrap
);

  generate
    if ((N_SEL < 1) || (N_SEL > 6)) begin : g_bad_nsel
      $error("dec_scan: N_SEL must be in 1..6");
    end
  endgenerate

  mode_e            mode_s;
  scan_state_e      state_r;
  logic             prev_en_r;
  logic             scan_go_s;
  logic             clear_s;
  logic             tick_s;
  logic             wrap_s;
  logic [N_SEL-1:0] scan_idx_r;
  logic [N_SEL-1:0] scan_next_s;
  logic [W-1:0]     out_r;
  logic [N_SEL-1:0] idx_r;
  logic             wrap_r;

  dec_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .clear  (clear_s),
    .tick   (tick_s)
  );

  // Scan stepping: a fresh scan shows i_in, a running scan advances on each tick.
  always_comb begin
    mode_s    = mode_e'(i_mode);
    scan_go_s = i_en && (mode_s == MODE_SCAN);
    clear_s   = !(scan_go_s && (state_r == ST_RUN));
    if (state_r == ST_RUN) begin
      if (tick_s) begin
        scan_next_s = scan_idx_r + N_SEL'(1'b1);
      end else begin
        scan_next_s = scan_idx_r;
      end
    end else begin
      scan_next_s = i_in;
    end
    wrap_s = (state_r == ST_RUN) && tick_s && (scan_idx_r == {N_SEL{1'b1}});
  end

  // Scan FSM plus registered decode; outputs default to zero so no mode leaves a residue.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r    <= ST_IDLE;
      scan_idx_r <= '0;
      prev_en_r  <= 1'b0;
      out_r      <= '0;
      idx_r      <= '0;
      wrap_r     <= 1'b0;
    end else begin
      prev_en_r <= i_en;
      out_r     <= '0;
      idx_r     <= '0;
      wrap_r    <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (scan_go_s) begin
            state_r    <= ST_RUN;
            scan_idx_r <= i_in;
          end else begin
            scan_idx_r <= '0;
          end
        end
        ST_RUN: begin
          if (scan_go_s) begin
            scan_idx_r <= scan_next_s;
          end else begin
            state_r    <= ST_IDLE;
            scan_idx_r <= '0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          scan_idx_r <= '0;
        end
      endcase

      case (mode_s)
        MODE_DIRECT: begin
          if (i_en) begin
            out_r <= W'(1'b1) << i_in;
            idx_r <= i_in;
          end
        end
        MODE_PULSE: begin
          if (en_rise(i_en, prev_en_r)) begin
            out_r <= W'(1'b1) << i_in;
            idx_r <= i_in;
          end
        end
        MODE_SCAN: begin
          if (scan_go_s) begin
            out_r  <= W'(1'b1) << scan_next_s;
            idx_r  <= scan_next_s;
            wrap_r <= wrap_s;
          end
        end
        MODE_OFF: begin
          out_r <= '0;
        end
        default: begin
          out_r <= '0;
        end
      endcase
    end
  end

  assign o_out  = out_r;
  assign o_idx  = idx_r;
  assign o_wrap = wrap_r;

endmodule

// File: tb/tb_dec_scan.sv
// Self-checking bench for dec_scan: directed scenarios plus random stress against a cycle-age model.
module tb_dec_scan;

  localparam int N_SEL    = 2;
  localparam int PRESCALE = 3;
  localparam int W        = 4;

  logic             i_clk  = 1'b0;
  logic             i_rstn = 1'b0;
  logic             i_en   = 1'b0;
  logic [1:0]       i_mode = 2'b00;
  logic [N_SEL-1:0] i_in   = '0;
  logic [W-1:0]     o_out;
  logic [N_SEL-1:0] o_idx;
  logic             o_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: scans are described by start index and age in cycles.
  int m_prev = 0;
  int m_run  = 0;
  int m_start = 0;
  int m_age  = 0;
  int exp_out = 0;
  int exp_idx = 0;
  int exp_wrap = 0;

  dec_scan #(.N_SEL(N_SEL), .PRESCALE(PRESCALE)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_en   (i_en),
    .i_mode (i_mode),
    .i_in   (i_in),
    .o_out  (o_out),
    .o_idx  (o_idx),
    .o_wrap (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rstn, input logic en, input logic [1:0] mode, input int in);
    exp_out  = 0;
    exp_idx  = 0;
    exp_wrap = 0;
    if (!rstn) begin
      m_prev = 0;
      m_run  = 0;
    end else begin
      if (mode == 2'b00 && en) begin
        exp_idx = in;
        exp_out = 1 << in;
      end else if (mode == 2'b01 && en && m_prev == 0) begin
        exp_idx = in;
        exp_out = 1 << in;
      end else if (mode == 2'b10 && en) begin
        if (m_run == 0) begin
          m_run = 1;
          m_start = in;
          m_age = 0;
        end else begin
          m_age++;
        end
        exp_idx  = (m_start + m_age / PRESCALE) % W;
        exp_out  = 1 << exp_idx;
        exp_wrap = (m_age > 0 && (m_age % PRESCALE) == 0 && exp_idx == 0) ? 1 : 0;
      end
      if (!(mode == 2'b10 && en)) m_run = 0;
      m_prev = en ? 1 : 0;
    end
  endtask

  task automatic step(input logic rstn, input logic en, input logic [1:0] mode, input int in);
    @(negedge i_clk);
    i_rstn = rstn;
    i_en   = en;
    i_mode = mode;
    i_in   = N_SEL'(in);
    @(posedge i_clk);
    model(rstn, en, mode, in);
    #1;
    chk("out",  32'(o_out),  32'(exp_out));
    chk("idx",  32'(o_idx),  32'(exp_idx));
    chk("wrap", 32'(o_wrap), 32'(exp_wrap));
  endtask

  int scan_seq [10] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

  initial begin
    step(1'b0, 1'b1, 2'b10, 3);
    step(1'b0, 1'b1, 2'b00, 1);
    chk("reset_out", 32'(o_out), 32'd0);

    // Direct decode, one cycle of latency per input
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 2'b00, k);
      chk("direct_const", 32'(o_out), 32'(1 << k));
    end
    step(1'b1, 1'b0, 2'b00, 3);
    chk("direct_off", 32'(o_out), 32'd0);

    // Pulse on rising enable only, held high must not re-pulse
    step(1'b1, 1'b0, 2'b01, 2);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 2'b01, 2);
      chk("pulse_const", 32'(o_out), (k == 0) ? 32'h4 : 32'h0);
    end
    step(1'b1, 1'b0, 2'b01, 2);
    step(1'b1, 1'b1, 2'b01, 2);
    chk("pulse_second", 32'(o_out), 32'h4);
    step(1'b1, 1'b1, 2'b01, 2);

    // Scan from index 2 with a three-cycle dwell
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 2'b10, 2);
      chk("scan_seq", 32'(o_idx), 32'(scan_seq[k]));
      chk("scan_wrap", 32'(o_wrap), (k == 6) ? 32'd1 : 32'd0);
    end

    // Drop enable at index 3, restart from 1 ignoring later i_in
    for (int g = 0; g < 20 && exp_idx != 3; g++) step(1'b1, 1'b1, 2'b10, 0);
    chk("scan_at3", 32'(o_idx), 32'd3);
    step(1'b1, 1'b0, 2'b10, 1);
    chk("scan_gap", 32'(o_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 2'b10, (k == 0) ? 1 : 3);
      chk("scan_restart", 32'(o_idx), (k < 3) ? 32'd1 : 32'd2);
    end

    // Reset mid-scan then a single pulse with enable held through release
    for (int g = 0; g < 20 && exp_idx != 3; g++) step(1'b1, 1'b1, 2'b10, 0);
    step(1'b0, 1'b1, 2'b10, 0);
    chk("rst_mid_out", 32'(o_out), 32'd0);
    chk("rst_mid_idx", 32'(o_idx), 32'd0);
    step(1'b1, 1'b1, 2'b01, 3);
    chk("rst_pulse", 32'(o_out), 32'h8);
    step(1'b1, 1'b1, 2'b01, 3);
    chk("rst_pulse_end", 32'(o_out), 32'd0);

    // OFF mode ignores enable and select
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 2'b11, k % W);
      chk("off_zero", {30'd0, o_wrap, |o_out} | 32'(o_idx), 32'd0);
    end

    // Random stress of mode, enable, select and reset
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), int'($urandom_range(0, W - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_scan.md
DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 Parameter N_SEL, default 2, select width (legal 1..6); output width W = 2**N_SEL.
REQ-002 Parameter PRESCALE, default 4, cycles per scan step in SCAN mode (legal >= 1).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  reset, synchronous, active-low.
REQ-005 i_en  input  1  enable; low forces all-zero output.
REQ-006 i_mode  input  2  00 DIRECT, 01 PULSE, 10 SCAN, 11 OFF.
REQ-007 i_in  input  N_SEL  select index (DIRECT/PULSE), scan start index (SCAN).
REQ-008 o_out  output  W  registered one-hot decode, or all-zero.
REQ-009 o_idx  output  N_SEL  index currently decoded on o_out; 0 when o_out is zero.
REQ-010 o_wrap  output  1  one-cycle pulse when SCAN index wraps from W-1 to 0.

Function
REQ-011 All outputs SHALL be registered; a change at i_in/i_en/i_mode appears on outputs exactly 1 cycle later.
REQ-012 o_out SHALL be either all-zero or have exactly one bit set, bit position == o_idx.
REQ-013 DIRECT: if i_en=1, o_out <= 1<<i_in next cycle; else 0.
REQ-014 PULSE: on cycle where i_en=1 and registered previous i_en=0, o_out <= 1<<i_in for exactly one cycle, then 0; held-high i_en SHALL NOT re-pulse.
REQ-015 PULSE: a mode change into PULSE with i_en already high SHALL NOT pulse; a new rising edge is required.
REQ-016 SCAN FSM states IDLE, RUN; IDLE->RUN when i_mode=SCAN and i_en=1; RUN->IDLE when i_en=0 or i_mode!=SCAN.
REQ-017 On IDLE->RUN transition cycle: index loads i_in, prescale count loads 0; o_out <= 1<<i_in next cycle.
REQ-018 In RUN, prescale counter counts 0..PRESCALE-1; at PRESCALE-1 it returns to 0 and index increments by 1 modulo W.
REQ-019 Each index value SHALL be displayed for exactly PRESCALE cycles; PRESCALE=1 steps every cycle.
REQ-020 o_wrap SHALL be 1 for the single cycle in which o_idx first shows 0 after W-1; never asserted outside SCAN.
REQ-021 In RUN, i_in changes SHALL be ignored.
REQ-022 Leaving RUN clears index and prescale counter; o_out <= 0 next cycle (unless new mode decodes).
REQ-023 OFF (11) SHALL drive o_out=0, o_idx=0, o_wrap=0 regardless of i_en.
REQ-024 Mode change mid-operation takes effect on the next cycle with no residual pulse from the old mode.

Reset
REQ-025 While i_rstn=0 at a rising edge: o_out=0, o_idx=0, o_wrap=0, FSM=IDLE, counters=0, previous-i_en register=0.
REQ-026 Reset SHALL override all other inputs, including mid-scan; first post-reset output follows REQ-011 latency.
REQ-027 i_en=1 held through reset release in PULSE mode SHALL produce one pulse (previous-i_en reset to 0).

Structure
REQ-028 Package dec_pkg SHALL hold mode encodings (MODE_DIRECT, MODE_PULSE, MODE_SCAN, MODE_OFF) and FSM state encodings.
REQ-029 Prescaler SHALL be a sub-module dec_tick_gen (params PRESCALE; inputs i_clk, i_rstn, clear; output one-cycle tick).
REQ-030 Parameter legality SHALL be checked at elaboration; illegal values fail elaboration.

Verification (N_SEL=2, PRESCALE=3)
REQ-031 DIRECT, i_en=1, i_in=0,1,2,3 on consecutive cycles -> o_out 0001,0010,0100,1000 each one cycle later; i_en=0 -> 0000.
REQ-032 PULSE, i_in=2, i_en 0->1 held 10 cycles -> o_out=0100 for exactly 1 cycle, then 0000; second rising edge -> second pulse.
REQ-033 SCAN, i_in=2, i_en=1 -> o_idx sequence 2,2,2,3,3,3,0,0,0,1...; o_wrap=1 only on first cycle of idx 0.
REQ-034 SCAN running, i_en->0 at idx=3 then back to 1 with i_in=1 -> output 0000 one cycle, restart at idx 1 with full 3-cycle dwell.
REQ-035 i_rstn=0 mid-scan (idx=3) -> next cycle all outputs 0; release with i_mode=PULSE, i_en=1 -> single pulse.
REQ-036 Mode 11 with i_en=1 and varying i_in -> o_out, o_idx, o_wrap remain 0; random mode/enable stress checks REQ-012 every cycle.
